// File: rtl/ioshim_pkg.sv
// ioshim shared definitions: address/data widths and the
// read-engine FSM state encoding used across the ioshim blocks.
package ioshim_pkg;
  localparam int IOSHIM_AW = 11;
  localparam int IOSHIM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } ioshim_state_t;
endpackage

// File: rtl/ioshim_fifo2.sv
// 2-entry sync FIFO (data+last) with push/pop/flush and count.
// Ports: clk, reset, i_push, i_data, i_pop, i_flush, o_data, o_count.
module ioshim_fifo2
  import ioshim_pkg::*;
#(
  parameter int W = IOSHIM_DW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // a full FIFO still takes a push when the head leaves the same cycle
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_count = r_count;

endmodule

// File: rtl/ioshim_memrd.sv
// Streaming read engine: walks a wrapping address range through a
// 1-cycle-latency read port and emits words on a valid/ready stream.
// Ports: clk, reset, start, start_addr, length, abort, busy, done,
//        mem_addr, mem_rdata, out_valid, out_ready, out_data, out_last.
module ioshim_memrd
  import ioshim_pkg::*;
#(
  parameter int MEMSIZE = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IOSHIM_AW-1:0] start_addr,
  input  logic [11:0]          length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [IOSHIM_AW-1:0] mem_addr,
  input  logic [IOSHIM_DW-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IOSHIM_DW-1:0] out_data,
  output logic                 out_last
);

  localparam logic [IOSHIM_AW-1:0] MASK = IOSHIM_AW'(MEMSIZE - 1);

  ioshim_state_t        r_state;
  ioshim_state_t        w_next;
  logic [IOSHIM_AW-1:0] r_ptr;
  logic [11:0]          r_remain;
  logic [11:0]          r_push_left;
  logic                 r_inflight;
  logic                 r_done;

  logic                 w_start;
  logic                 w_issue;
  logic                 w_drain_done;
  logic                 w_pop;
  logic                 w_push;
  logic [2:0]           w_occ;
  logic [1:0]           w_count;
  logic [IOSHIM_DW:0]   w_head;

  assign w_start = start && !abort && (r_state == ST_IDLE);
  assign w_pop   = out_valid && out_ready;
  assign w_push  = r_inflight && !abort;
  // words held or on their way after this cycle's pop
  assign w_occ   = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};

  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_drain_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = (length == 12'd0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        w_issue = (w_occ < 3'd2);
        if (w_issue && (r_remain == 12'd1)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // second term only ever fires for a zero-length transfer
        if ((w_pop && w_head[IOSHIM_DW]) ||
            ((r_push_left == 12'd0) && !r_inflight && (w_count == 2'd0))) begin
          w_next       = ST_IDLE;
          w_drain_done = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next       = ST_IDLE;
      w_issue      = 1'b0;
      w_drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remain    <= '0;
      r_push_left <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      r_done     <= w_drain_done;
      if (w_start) begin
        r_ptr       <= start_addr & MASK;
        r_remain    <= length;
        r_push_left <= length;
      end else begin
        if (w_issue) begin
          r_ptr    <= (r_ptr + 1'b1) & MASK;
          r_remain <= r_remain - 12'd1;
        end
        if (w_push) r_push_left <= r_push_left - 12'd1;
      end
    end
  end

  ioshim_fifo2 #(
    .W(IOSHIM_DW + 1)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data ({(r_push_left == 12'd1), mem_rdata}),
    .i_pop  (w_pop),
    .i_flush(abort),
    .o_data (w_head),
    .o_count(w_count)
  );

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign mem_addr  = r_ptr;
  assign out_valid = (w_count != 2'd0);
  assign out_data  = w_head[IOSHIM_DW-1:0];
  assign out_last  = out_valid && w_head[IOSHIM_DW];

endmodule

// File: tb/tb_ioshim_memrd.sv
// Bench for ioshim_memrd: two instances (MEMSIZE 128 and 2048) share
// stimulus; a queue model of expected beats checks every cycle.
module tb_ioshim_memrd;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [10:0] start_addr;
  logic [11:0] length;

  logic        busy_a, done_a, v_a, last_a;
  logic [10:0] ma_a;
  logic [15:0] rd_a, data_a;
  logic        busy_b, done_b, v_b, last_b;
  logic [10:0] ma_b;
  logic [15:0] rd_b, data_b;

  logic [15:0] mem [2048];
  logic        sel = 1'b0;
  logic        mon_en = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [16:0] q[$];
  logic        m_busy = 1'b0;
  logic        m_done_due = 1'b0;
  logic        m_zero = 1'b0;
  int          m_beats = 0;
  logic [15:0] m_last_data = 16'h0;

  always #5 clk = ~clk;

  ioshim_memrd #(.MEMSIZE(128)) dut_a (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(busy_a), .done(done_a),
    .mem_addr(ma_a), .mem_rdata(rd_a), .out_valid(v_a),
    .out_ready(out_ready), .out_data(data_a), .out_last(last_a)
  );

  ioshim_memrd #(.MEMSIZE(2048)) dut_b (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(busy_b), .done(done_b),
    .mem_addr(ma_b), .mem_rdata(rd_b), .out_valid(v_b),
    .out_ready(out_ready), .out_data(data_b), .out_last(last_b)
  );

  always @(posedge clk) begin
    rd_a <= mem[ma_a];
    rd_b <= mem[ma_b];
  end

  wire        s_busy = sel ? busy_b : busy_a;
  wire        s_done = sel ? done_b : done_a;
  wire        s_valid = sel ? v_b : v_a;
  wire        s_last = sel ? last_b : last_a;
  wire [15:0] s_data = sel ? data_b : data_a;
  wire [10:0] s_maddr = sel ? ma_b : ma_a;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  function automatic logic rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // behavioural model: list of expected beats per accepted start
  always @(negedge clk) begin
    if (mon_en) begin
      logic was_busy;
      int ms;
      chk("busy", s_busy, m_busy);
      chk("done", s_done, m_done_due);
      if (s_valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("data", s_data, q[0][15:0]);
          chk("last", s_last, q[0][16]);
        end
      end
      was_busy = m_busy;
      m_done_due = 1'b0;
      if (m_zero) begin
        m_zero = 1'b0;
        m_done_due = 1'b1;
        m_busy = 1'b0;
      end
      if (s_valid && out_ready && q.size() > 0) begin
        m_last_data = q[0][15:0];
        m_beats++;
        if (q[0][16]) begin
          m_done_due = 1'b1;
          m_busy = 1'b0;
        end
        void'(q.pop_front());
      end
      if (reset || abort) begin
        q.delete();
        m_busy = 1'b0;
        m_done_due = 1'b0;
        m_zero = 1'b0;
      end else if (start && !was_busy) begin
        ms = sel ? 2048 : 128;
        for (int i = 0; i < int'(length); i++) begin
          int a;
          a = (int'(start_addr) % ms + i) % ms;
          q.push_back({(i == int'(length) - 1), mem[a]});
        end
        m_busy = 1'b1;
        if (length == 12'd0) m_zero = 1'b1;
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      out_ready = rnd(50);
    end
  endtask

  // call at #1 after an edge; start is driven in that cycle (cycle 0)
  task automatic xfer(input logic [10:0] sa, input int n, input int pct,
                      input int abort_at, input int reset_at, input int poke,
                      output int done_cyc, output int first_v,
                      output int beats);
    int b0, stop, lim;
    logic [10:0] msk;
    b0 = m_beats;
    stop = -1;
    done_cyc = -1;
    first_v = -1;
    lim = 20 * n + 60;
    msk = sel ? 11'h7FF : 11'h07F;
    start = 1'b1;
    start_addr = sa;
    length = 12'(n);
    out_ready = rnd(pct);
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      out_ready = rnd(pct);
      if (cyc == poke) begin
        start = 1'b1;
        start_addr = sa + 11'd3;
        length = 12'd9;
      end
      if (cyc == 1) chk("mem_addr_c1", s_maddr, sa & msk);
      if (first_v < 0 && s_valid) first_v = cyc;
      if (cyc == stop) begin
        chk("stop_valid", s_valid, 0);
        chk("stop_busy", s_busy, 0);
        if (reset_at >= 0) begin
          chk("rst_done", s_done, 0);
          chk("rst_last", s_last, 0);
          chk("rst_data", s_data, 0);
          chk("rst_maddr", s_maddr, 0);
          break;
        end
      end
      if (stop > 0 && cyc == stop + 5) break;
      if (s_done) begin
        done_cyc = cyc;
        break;
      end
      if (stop < 0 && abort_at >= 0 && m_beats - b0 == abort_at) begin
        abort = 1'b1;
        stop = cyc + 1;
      end
      if (stop < 0 && reset_at >= 0 && m_beats - b0 == reset_at) begin
        reset = 1'b1;
        stop = cyc + 1;
      end
    end
    beats = m_beats - b0;
    if (abort_at < 0 && reset_at < 0) chk("done_seen", done_cyc >= 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int dc, fv, bt;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    start_addr = '0;
    length = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    chk("r_busy", s_busy, 0);
    chk("r_done", s_done, 0);
    chk("r_valid", s_valid, 0);
    chk("r_last", s_last, 0);
    chk("r_data", s_data, 0);
    chk("r_maddr", s_maddr, 0);
    idle(1);

    xfer(11'd20, 10, 100, -1, 4, -1, dc, fv, bt);
    idle(2);
    xfer(11'd0, 3, 100, -1, -1, -1, dc, fv, bt);
    chk("post_rst_beats", bt, 3);
    chk("post_rst_done", dc, 6);
    idle(2);

    xfer(11'h07E, 4, 100, -1, -1, -1, dc, fv, bt);
    chk("wrap_done_cyc", dc, 7);
    chk("wrap_first_v", fv, 3);
    chk("wrap_beats", bt, 4);
    chk("wrap_last_word", m_last_data, mem[1]);
    idle(2);

    xfer(11'd40, 16, 30, -1, -1, -1, dc, fv, bt);
    chk("bp_beats", bt, 16);
    idle(2);

    xfer(11'd60, 20, 50, 5, -1, -1, dc, fv, bt);
    chk("abort_no_done", dc, -1);
    chk("abort_beats", (bt == 5) || (bt == 6), 1);
    idle(1);
    xfer(11'd100, 2, 60, -1, -1, -1, dc, fv, bt);
    chk("post_abort_beats", bt, 2);
    idle(2);

    xfer(11'd9, 0, 100, -1, -1, -1, dc, fv, bt);
    chk("zero_done_cyc", dc, 2);
    chk("zero_no_valid", fv, -1);
    chk("zero_beats", bt, 0);
    idle(2);

    sel = 1'b1;
    xfer(11'd5, 2048, 100, -1, -1, -1, dc, fv, bt);
    chk("full_beats", bt, 2048);
    chk("full_done_cyc", dc, 2051);
    chk("full_last_word", m_last_data, mem[4]);
    idle(2);

    sel = 1'b0;
    xfer(11'd30, 6, 60, -1, -1, 2, dc, fv, bt);
    chk("poke_beats", bt, 6);
    xfer(11'd9, 3, 100, -1, -1, -1, dc, fv, bt);
    chk("chain_beats", bt, 3);
    chk("chain_done_cyc", dc, 6);
    idle(2);

    for (int k = 0; k < 12; k++) begin
      int n, ab;
      sel = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 40);
      ab = (n > 4 && $urandom_range(0, 3) == 0) ? 3 : -1;
      xfer(11'($urandom), n, $urandom_range(20, 100), ab, -1, -1,
           dc, fv, bt);
      if (ab < 0) chk("rnd_beats", bt, n);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
